// File: rtl/adc_frame_if.sv
// adc_frame_if: FIFO pop side and sample stream of the ADC frame reader.
// master = reader, slave = FIFO/downstream side.
interface adc_frame_if;
   logic [31:0] i_fifo_data;
   logic        i_fifo_empty;
   logic        o_fifo_rd;
   logic [7:0]  o_data;
   logic        o_vld;
   logic        i_rdy;

   modport master (
      input  i_fifo_data, i_fifo_empty, i_rdy,
      output o_fifo_rd, o_data, o_vld
   );

   modport slave (
      output i_fifo_data, i_fifo_empty, i_rdy,
      input  o_fifo_rd, o_data, o_vld
   );
endinterface

// File: rtl/adc_frame_reader.sv
// adc_frame_reader: unpacks FWFT FIFO words into an 8-bit sample stream.
// Define ADC_REPEAT_EN to add i_ratio sample repetition.
module adc_frame_reader #(
   parameter int LEN_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [LEN_W-1:0] i_length,
`ifdef ADC_REPEAT_EN
   input  logic [7:0]       i_ratio,
`endif
   adc_frame_if.master      bus,
   output logic             o_busy,
   output logic             o_done
);

   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

   state_t           state;
   logic [LEN_W-1:0] remaining;
   logic [31:0]      word;
   logic [1:0]       idx;
   logic [1:0]       idx_nx;
   logic             hs;
   logic             last;
   logic             rep_last;
   logic             adv_word;

   assign hs     = bus.o_vld && bus.i_rdy;
   assign last   = (remaining == LEN_W'(1));
   assign idx_nx = idx + 2'd1;

`ifdef ADC_REPEAT_EN
   logic [7:0] ratio;
   logic [7:0] rep_cnt;

   // ratio 0 and 1 both mean a single handshake per byte
   assign rep_last = (ratio <= 8'd1) || (rep_cnt == ratio - 8'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ratio   <= '0;
         rep_cnt <= '0;
      end else begin
         if (state == IDLE && i_start && !i_abort)
            ratio <= i_ratio;
         if (state == FETCH || (hs && rep_last))
            rep_cnt <= '0;
         else if (hs)
            rep_cnt <= rep_cnt + 8'd1;
      end
   end
`else
   assign rep_last = 1'b1;
`endif

   assign adv_word = (state == SHIFT) && hs && !last
                     && rep_last && (idx == 2'd3);

   always_comb begin
      bus.o_fifo_rd = 1'b0;
      if (!i_abort && !bus.i_fifo_empty)
         bus.o_fifo_rd = (state == FETCH) || adv_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         remaining  <= '0;
         word       <= '0;
         idx        <= '0;
         bus.o_data <= '0;
         bus.o_vld  <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else if (i_abort) begin
         state     <= IDLE;
         bus.o_vld <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  remaining <= i_length;
                  if (i_length != '0) begin
                     state  <= FETCH;
                     o_busy <= 1'b1;
                  end else begin
                     state  <= DONE;
                     o_done <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (!bus.i_fifo_empty) begin
                  word       <= bus.i_fifo_data;
                  idx        <= 2'd0;
                  bus.o_data <= bus.i_fifo_data[7:0];
                  bus.o_vld  <= 1'b1;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               if (hs) begin
                  remaining <= remaining - LEN_W'(1);
                  if (last) begin
                     // leftover bytes of the popped word are dropped
                     bus.o_vld <= 1'b0;
                     o_busy    <= 1'b0;
                     o_done    <= 1'b1;
                     state     <= DONE;
                  end else if (rep_last) begin
                     if (idx != 2'd3) begin
                        idx        <= idx_nx;
                        bus.o_data <= word[{idx_nx, 3'b000} +: 8];
                     end else if (!bus.i_fifo_empty) begin
                        word       <= bus.i_fifo_data;
                        idx        <= 2'd0;
                        bus.o_data <= bus.i_fifo_data[7:0];
                     end else begin
                        bus.o_vld <= 1'b0;
                        state     <= FETCH;
                     end
                  end
               end
            end
            DONE: begin
               o_done <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/adc_frame_reader.md
Name: adc_frame_reader

Overview:
- Consumer side of the decimated ADC capture path. Pops packed 32-bit sample words from a show-ahead (FWFT) FIFO filled by the capture/alignment logic.
- Unpacks each word into 8-bit samples and streams them to the display/readout side over a valid/ready handshake.
- A frame is started by a pulse and carries a programmed sample count. Completion is reported with a one-cycle done pulse.

Parameters:
- LEN_W, 12, width of frame sample-count input and internal remaining counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- i_start  input  1  one-cycle pulse; begin frame (ignored while o_busy).
- i_abort  input  1  terminate current frame immediately, no done pulse.
- i_length  input  LEN_W  samples (bytes) in frame; sampled on accepted i_start.
- i_fifo_data  input  32  FWFT FIFO head word, valid while i_fifo_empty=0.
- i_fifo_empty  input  1  FIFO empty flag.
- o_fifo_rd  output  1  pop FIFO head (combinational, only when i_fifo_empty=0).
- o_data  output  8  current sample (registered).
- o_vld  output  1  o_data valid (registered).
- i_rdy  input  1  downstream accepts o_data when o_vld&&i_rdy.
- o_busy  output  1  frame in progress.
- o_done  output  1  one-cycle pulse after last sample accepted.
- i_ratio  input  8  sample repeat count (present only with ADC_REPEAT_EN).

Behaviour:
- Reset values: o_vld=0, o_data=0, o_fifo_rd=0, o_busy=0, o_done=0; state IDLE; counters 0.
- Byte order: first sample = word[7:0], then [15:8], [23:16], [31:24].
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE: o_busy=0. On i_start with i_length!=0: latch remaining=i_length, go FETCH. On i_start with i_length==0: go DONE, no FIFO pop.
- FETCH: o_busy=1. If !i_fifo_empty, assert o_fifo_rd and load i_fifo_data into the shift register. Set byte index=0, o_data=word[7:0], o_vld=1, go SHIFT. If the FIFO is empty, wait indefinitely.
- SHIFT: o_vld held with o_data stable until handshake. On o_vld&&i_rdy:
  - remaining decrements.
  - If remaining was 1: o_vld=0, go DONE. Unconsumed bytes of the current word are discarded; the word is already popped.
  - Else if index<3: index++, o_data=next byte, same cycle (no bubble).
  - Else if index==3 and !i_fifo_empty: pop and load the new word in the same cycle, index=0, o_vld stays 1 (zero-bubble streaming).
  - Else if index==3 and the FIFO is empty: o_vld=0, go FETCH.
- DONE: o_done=1 for exactly one cycle, o_busy=0, go IDLE.
- Latency: i_start to first o_vld is 2 cycles when the FIFO is non-empty. Steady throughput is 1 sample/cycle with i_rdy=1.
- i_abort in any state has priority over everything except reset. Next cycle: IDLE, o_vld=0, no o_done, no pop in the abort cycle.
- i_start and i_abort in the same cycle: abort wins, start ignored.
- o_fifo_rd is never asserted when i_fifo_empty=1. At most one pop per cycle.
- Reset mid-frame: immediate return to reset values. FIFO content is untouched.

Optional Feature:
- Macro ADC_REPEAT_EN.
- Defined: i_ratio port exists and is latched on accepted i_start. Each sample is presented for max(i_ratio,1) consecutive handshakes before advancing (inverse of capture decimation). remaining counts output handshakes, i.e. i_length is the total output samples. An internal 8-bit repeat counter is reset on every byte advance.
- Not defined: i_ratio port and repeat counter absent. Each byte is emitted exactly once.

Test Plan:
- FIFO preloaded with 0x44332211, 0x88776655; start, length=8, i_rdy=1 -> o_data 11,22,...,88 on 8 consecutive cycles. One o_done the cycle after 88. 2 pops, no o_vld gaps.
- Same FIFO contents, length=5 -> samples 11..55, then o_done. Both words popped; bytes 66,77,88 dropped; o_busy=0 after.
- i_rdy toggled 1,0,0,1,... -> o_data held stable while i_rdy=0. Sequence unchanged, no duplicates or skips.
- FIFO empty at start, word 0xDDCCBBAA written 10 cycles later, length=4 -> o_vld stays 0 and o_fifo_rd stays 0 while empty. Then AA,BB,CC,DD.
- Abort after 3 samples of length=8 -> o_vld=0 next cycle, no o_done. A new start with length=0 -> o_done pulse 1 cycle later, no pop.
- ADC_REPEAT_EN, i_ratio=3, word 0x00002211, length=6 -> 11,11,11,22,22,22, then o_done. i_ratio=0 behaves as 1.
